// File: rtl/lcd_cmd_pkg.sv
// Package: lcd_cmd_pkg
// Shared types and constants for the PMOD CLS command sequencer.
//  - t_cmd_state : sequencer FSM states
//  - t_cmd_kind  : command being expanded (clear, line 1, line 2)
//  - PMOD CLS escape-sequence byte constants and stream lengths
//  - f_cmd_byte  : returns byte <idx> of the escape stream for a command
package lcd_cmd_pkg;

  localparam int c_line_chars = 16;
  localparam int c_text_w     = 8 * c_line_chars;

  // Stream lengths: clear = ESC [ j, line = ESC [ r ; 0 H + text
  localparam logic [4:0] c_len_clear = 5'd3;
  localparam logic [4:0] c_len_line  = 5'd22;

  localparam logic [7:0] c_esc  = 8'h1B;  // ESC
  localparam logic [7:0] c_lbr  = 8'h5B;  // '['
  localparam logic [7:0] c_clr  = 8'h6A;  // 'j' : clear display, cursor home
  localparam logic [7:0] c_row0 = 8'h30;  // '0' : row 0
  localparam logic [7:0] c_row1 = 8'h31;  // '1' : row 1
  localparam logic [7:0] c_semi = 8'h3B;  // ';'
  localparam logic [7:0] c_col0 = 8'h30;  // '0' : column 0
  localparam logic [7:0] c_cup  = 8'h48;  // 'H' : cursor position

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENQ,
    ST_GO,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } t_cmd_state;

  typedef enum logic [1:0] {
    CMD_CLEAR,
    CMD_LINE1,
    CMD_LINE2
  } t_cmd_kind;

  // Byte <idx> of the escape stream. Text bytes start at index 6 and are
  // taken MSB-first, so char 0 lives in text[c_text_w-1 -: 8].
  function automatic logic [7:0] f_cmd_byte(
    input t_cmd_kind             kind,
    input logic [4:0]            idx,
    input logic [c_text_w-1:0]   text
  );
    logic [7:0]          b;
    logic [c_text_w-1:0] shifted;
    shifted = '0;
    if (idx == 5'd0) begin
      b = c_esc;
    end else if (idx == 5'd1) begin
      b = c_lbr;
    end else if (kind == CMD_CLEAR) begin
      b = c_clr;
    end else begin
      case (idx)
        5'd2:    b = (kind == CMD_LINE2) ? c_row1 : c_row0;
        5'd3:    b = c_semi;
        5'd4:    b = c_col0;
        5'd5:    b = c_cup;
        default: begin
          shifted = text << (8 * (idx - 5'd6));
          b = shifted[c_text_w-1 -: 8];
        end
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/pmod_cls_cmd_seq.sv
// Module: pmod_cls_cmd_seq
// Command sequencer between the two-line LCD text feed and the SPI master
// driving a PMOD CLS display. One strobe (clear / line 1 / line 2) is
// expanded into its escape-sequence byte stream, pushed into the SPI TX
// FIFO, then the SPI burst is launched and the block stays busy until the
// SPI master returns to idle.
// Ports:
//  i_clk_40mhz / i_rst_40mhz      clock, synchronous active-high reset
//  i_wr_clear_display, i_wr_text_line1, i_wr_text_line2
//                                 command strobes, sampled only while ready
//  i_dat_ascii_line1/2            line text, char 0 in the top byte
//  o_command_ready                high only while idle
//  o_tx_data / o_tx_enqueue       FIFO write byte and one-cycle strobe
//  i_tx_full                      FIFO full, blocks enqueue
//  o_go_stand / o_tx_len          one-cycle burst launch and byte count
//  i_spi_idle                     SPI master idle
//  o_timeout_err                  sticky: SPI never went busy after go
module pmod_cls_cmd_seq
  import lcd_cmd_pkg::*;
#(
  parameter int parm_line_chars   = 16,
  parameter int parm_busy_timeout = 1000
) (
  input  logic                           i_clk_40mhz,
  input  logic                           i_rst_40mhz,
  input  logic                           i_wr_clear_display,
  input  logic                           i_wr_text_line1,
  input  logic                           i_wr_text_line2,
  input  logic [8*parm_line_chars-1:0]   i_dat_ascii_line1,
  input  logic [8*parm_line_chars-1:0]   i_dat_ascii_line2,
  output logic                           o_command_ready,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_enqueue,
  input  logic                           i_tx_full,
  output logic                           o_go_stand,
  output logic [4:0]                     o_tx_len,
  input  logic                           i_spi_idle,
  output logic                           o_timeout_err
);

  localparam logic [15:0] c_tmo_last = 16'(parm_busy_timeout - 1);

  t_cmd_state            state_reg, state_next;
  t_cmd_kind             kind_reg, kind_sel;
  logic [c_text_w-1:0]   text_reg;
  logic [4:0]            idx_reg;
  logic [15:0]           tmo_cnt_reg;

  logic                  ready_reg;
  logic [7:0]            tx_data_reg;
  logic                  tx_enqueue_reg;
  logic                  go_reg;
  logic [4:0]            tx_len_reg;
  logic                  timeout_err_reg;

  logic                  accept;
  logic                  enq_fire;
  logic                  last_byte;
  logic                  timeout_hit;

  assign enq_fire    = (state_reg == ST_ENQ) && !i_tx_full;
  assign last_byte   = (idx_reg == tx_len_reg - 5'd1);
  assign timeout_hit = (state_reg == ST_WAIT_BUSY) && i_spi_idle &&
                       (tmo_cnt_reg == c_tmo_last);

  // Next state, plus strobe priority resolution (clear > line1 > line2).
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    if (i_wr_clear_display) begin
      kind_sel = CMD_CLEAR;
    end else if (i_wr_text_line1) begin
      kind_sel = CMD_LINE1;
    end else begin
      kind_sel = CMD_LINE2;
    end
    case (state_reg)
      ST_IDLE: begin
        if (i_wr_clear_display || i_wr_text_line1 || i_wr_text_line2) begin
          accept     = 1'b1;
          state_next = ST_ENQ;
        end
      end
      ST_ENQ: begin
        if (enq_fire && last_byte) begin
          state_next = ST_GO;
        end
      end
      ST_GO: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!i_spi_idle) begin
          state_next = ST_WAIT_DONE;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_spi_idle) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, command snapshot, byte index and busy-timeout counter.
  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) begin
      state_reg   <= ST_IDLE;
      kind_reg    <= CMD_CLEAR;
      text_reg    <= '0;
      idx_reg     <= 5'd0;
      tmo_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        kind_reg <= kind_sel;
        // Snapshot so upstream text edits cannot corrupt the running burst.
        text_reg <= (kind_sel == CMD_LINE2) ? i_dat_ascii_line2 : i_dat_ascii_line1;
      end
      // Index saturates at len-1 and restarts whenever we return to idle.
      if (state_next == ST_IDLE) begin
        idx_reg <= 5'd0;
      end else if (enq_fire && !last_byte) begin
        idx_reg <= idx_reg + 5'd1;
      end
      if (state_reg == ST_GO) begin
        tmo_cnt_reg <= 16'd0;
      end else if (state_reg == ST_WAIT_BUSY && tmo_cnt_reg != 16'hFFFF) begin
        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      end
    end
  end

  // Registered outputs. Ready is registered from the next state so it
  // tracks "state is idle" exactly, one cycle after a strobe is taken.
  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) begin
      ready_reg       <= 1'b1;
      tx_data_reg     <= 8'h00;
      tx_enqueue_reg  <= 1'b0;
      go_reg          <= 1'b0;
      tx_len_reg      <= 5'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      ready_reg      <= (state_next == ST_IDLE);
      tx_enqueue_reg <= enq_fire;
      go_reg         <= (state_reg == ST_GO);
      if (enq_fire) begin
        tx_data_reg <= f_cmd_byte(kind_reg, idx_reg, text_reg);
      end
      if (accept) begin
        tx_len_reg <= (kind_sel == CMD_CLEAR) ? c_len_clear : c_len_line;
      end
      if (timeout_hit) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  assign o_command_ready = ready_reg;
  assign o_tx_data       = tx_data_reg;
  assign o_tx_enqueue    = tx_enqueue_reg;
  assign o_go_stand      = go_reg;
  assign o_tx_len        = tx_len_reg;
  assign o_timeout_err   = timeout_err_reg;

endmodule
